// File: rtl/scan_decoder_if.sv
// scan_decoder_if: bundles the enable/select inputs and the decoded outputs
// of scan_decoder.
//   e1, e2_n, e3_n : three-input enable (active high, low, low)
//   mode           : 0 = direct decode of sel, 1 = auto scan
//   sel            : channel select, direct mode only
//   y_n            : registered active-low one-hot outputs
//   cur_sel        : registered index of the decoded channel
//   tick           : one-cycle pulse when the scan index advances
// The master modport drives the controls; the slave modport is the decoder.
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int NUM_OUT = 1 << SEL_W;

    logic               e1;
    logic               e2_n;
    logic               e3_n;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [NUM_OUT-1:0] y_n;
    logic [SEL_W-1:0]   cur_sel;
    logic               tick;

    modport master (
        output e1, e2_n, e3_n, mode, sel,
        input  y_n, cur_sel, tick
    );

    modport slave (
        input  e1, e2_n, e3_n, mode, sel,
        output y_n, cur_sel, tick
    );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder: registered SEL_W-to-2^SEL_W decoder with active-low one-hot
// outputs and 74LS138-style enable gating, plus an auto-scan mode that steps
// the active output through channels 0..SCAN_LAST every PRESCALE clocks.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : scan_decoder_if slave (e1, e2_n, e3_n, mode, sel in;
//         y_n, cur_sel, tick out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
module scan_decoder #(
    parameter int SEL_W     = 3,
    parameter int SCAN_LAST = 3,
    parameter int PRESCALE  = 100000
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);
    localparam int NUM_OUT = 1 << SEL_W;
    localparam int PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST      = PSC_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] SCAN_LAST_IDX = SEL_W'(SCAN_LAST);

    logic               en_s;
    logic [SEL_W-1:0]   cur_sel_d, cur_sel_q;
    logic [PSC_W-1:0]   psc_d,     psc_q;
    logic               tick_d,    tick_q;
    logic [NUM_OUT-1:0] y_n_d,     y_n_q;

    // Next-state logic for the index, prescaler, tick and decoded outputs.
    always_comb begin
        en_s      = bus.e1 & ~bus.e2_n & ~bus.e3_n;
        cur_sel_d = cur_sel_q;
        psc_d     = psc_q;
        tick_d    = 1'b0;
        y_n_d     = {NUM_OUT{1'b1}};

        if (!en_s) begin
            // Disabled: index and count freeze so re-enable resumes exactly.
            cur_sel_d = cur_sel_q;
            psc_d     = psc_q;
        end else if (!bus.mode) begin
            // Direct decode; the cleared prescaler makes a later switch to
            // scan wait a full PRESCALE period before the first step.
            cur_sel_d = bus.sel;
            psc_d     = {PSC_W{1'b0}};
        end else if (psc_q == PSC_LAST) begin
            psc_d  = {PSC_W{1'b0}};
            tick_d = 1'b1;
            // '>=' also folds an out-of-range index left by direct mode to 0.
            if (cur_sel_q >= SCAN_LAST_IDX) begin
                cur_sel_d = {SEL_W{1'b0}};
            end else begin
                cur_sel_d = cur_sel_q + SEL_W'(1);
            end
        end else begin
            psc_d = psc_q + PSC_W'(1);
        end

        // y_n is the image of the index being loaded this edge.
        if (en_s) begin
            y_n_d[cur_sel_d] = 1'b0;
        end else begin
            y_n_d = {NUM_OUT{1'b1}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sel_q <= {SEL_W{1'b0}};
            psc_q     <= {PSC_W{1'b0}};
            tick_q    <= 1'b0;
            y_n_q     <= {NUM_OUT{1'b1}};
        end else begin
            cur_sel_q <= cur_sel_d;
            psc_q     <= psc_d;
            tick_q    <= tick_d;
            y_n_q     <= y_n_d;
        end
    end

    assign bus.y_n     = y_n_q;
    assign bus.cur_sel = cur_sel_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       e1, e2_n, e3_n, mode;
    logic [2:0] sel;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    scan_decoder_if #(.SEL_W(3)) bus4 ();
    scan_decoder_if #(.SEL_W(3)) bus1 ();

    assign bus4.e1 = e1;   assign bus4.e2_n = e2_n; assign bus4.e3_n = e3_n;
    assign bus4.mode = mode; assign bus4.sel = sel;
    assign bus1.e1 = e1;   assign bus1.e2_n = e2_n; assign bus1.e3_n = e3_n;
    assign bus1.mode = mode; assign bus1.sel = sel;

    scan_decoder #(.SEL_W(3), .SCAN_LAST(3), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave)
    );
    scan_decoder #(.SEL_W(3), .SCAN_LAST(3), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: [0] is PRESCALE=4, [1] is PRESCALE=1.
    int   pre [2] = '{4, 1};
    int   m_idx [2];
    int   m_cnt [2];
    bit   m_tick [2];
    logic [7:0] m_y [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit en;
        en = e1 && !e2_n && !e3_n;
        for (int d = 0; d < 2; d++) begin
            m_tick[d] = 1'b0;
            if (rst) begin
                m_idx[d] = 0;
                m_cnt[d] = 0;
                m_y[d]   = 8'hFF;
            end else if (!en) begin
                m_y[d] = 8'hFF;
            end else begin
                if (!mode) begin
                    m_idx[d] = sel;
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                    if (m_cnt[d] == pre[d]) begin
                        m_cnt[d]  = 0;
                        m_tick[d] = 1'b1;
                        m_idx[d]  = (m_idx[d] >= 3) ? 0 : m_idx[d] + 1;
                    end
                end
                m_y[d] = ~(8'h01 << m_idx[d]);
            end
        end
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    // Per-cycle comparison of both decoders against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("p4_y_n",    32'(bus4.y_n),     32'(m_y[0]));
            chk("p4_cur",    32'(bus4.cur_sel), 32'(m_idx[0] & 7));
            chk("p4_tick",   32'(bus4.tick),    32'(m_tick[0]));
            chk("p1_y_n",    32'(bus1.y_n),     32'(m_y[1]));
            chk("p1_cur",    32'(bus1.cur_sel), 32'(m_idx[1] & 7));
            chk("p1_tick",   32'(bus1.tick),    32'(m_tick[1]));
        end
    end

    logic [7:0] sweep_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    initial begin
        rst = 1'b1; e1 = 1'b1; e2_n = 1'b0; e3_n = 1'b0; mode = 1'b0; sel = 3'd5;
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_cnt[d] = 0; m_tick[d] = 1'b0; m_y[d] = 8'hFF;
        end
        chk_on = 1'b1;

        // Reset then direct decode of sel=5.
        step(3);
        chk("rst_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        chk("rst_cur", 32'(bus4.cur_sel), 32'h0);
        chk("rst_tick", 32'(bus4.tick), 32'h0);
        rst = 1'b0;
        step(1);
        chk("sel5_y_n", 32'(bus4.y_n), 32'h0000_00DF);
        chk("sel5_cur", 32'(bus4.cur_sel), 32'h5);

        // Direct sweep.
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step(1);
            chk("sweep_y_n", 32'(bus4.y_n), 32'(sweep_tab[i]));
        end

        // Each enable alone blanks the outputs and holds the index.
        sel = 3'd2; step(1);
        e1 = 1'b0; sel = 3'd6; step(1);
        chk("e1_off_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        chk("e1_off_cur", 32'(bus4.cur_sel), 32'h2);
        e1 = 1'b1; e2_n = 1'b1; step(1);
        chk("e2_off_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        e2_n = 1'b0; e3_n = 1'b1; step(1);
        chk("e3_off_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        e3_n = 1'b0;

        // Scan run from channel 0.
        sel = 3'd0; step(1);
        mode = 1'b1;
        step(3);
        chk("scan_pre_tick", 32'(bus4.tick), 32'h0);
        chk("scan_pre_y_n", 32'(bus4.y_n), 32'h0000_00FE);
        step(1);
        chk("scan_tick1", 32'(bus4.tick), 32'h1);
        chk("scan_y1", 32'(bus4.y_n), 32'h0000_00FD);
        sel = 3'd7;  // ignored while scanning
        step(16);
        chk("scan20_y_n", 32'(bus4.y_n), 32'h0000_00FD);
        chk("scan20_tick", 32'(bus4.tick), 32'h1);
        chk("p1_scan20_cur", 32'(bus1.cur_sel), 32'h0);

        // Freeze at prescaler=2, index=2, then resume.
        step(6);
        e1 = 1'b0;
        step(5);
        chk("frz_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        e1 = 1'b1;
        step(1);
        chk("res_cur", 32'(bus4.cur_sel), 32'h2);
        chk("res_y_n", 32'(bus4.y_n), 32'h0000_00FB);
        chk("res_tick0", 32'(bus4.tick), 32'h0);
        step(1);
        chk("res_tick1", 32'(bus4.tick), 32'h1);
        chk("res_cur3", 32'(bus4.cur_sel), 32'h3);

        // Out-of-range index entering scan mode.
        mode = 1'b0; sel = 3'd6; step(1);
        chk("oor_y_n0", 32'(bus4.y_n), 32'h0000_00BF);
        mode = 1'b1; step(3);
        chk("oor_y_n3", 32'(bus4.y_n), 32'h0000_00BF);
        step(1);
        chk("oor_tick", 32'(bus4.tick), 32'h1);
        chk("oor_y_wrap", 32'(bus4.y_n), 32'h0000_00FE);

        // Reset mid-scan at index 2, prescaler 3.
        step(11);
        chk("pre_rst_cur", 32'(bus4.cur_sel), 32'h2);
        rst = 1'b1; step(1);
        chk("mid_rst_y_n", 32'(bus4.y_n), 32'h0000_00FF);
        chk("mid_rst_tick", 32'(bus4.tick), 32'h0);
        rst = 1'b0; step(3);
        chk("post_rst_notick", 32'(bus4.tick), 32'h0);
        step(1);
        chk("post_rst_tick", 32'(bus4.tick), 32'h1);
        chk("post_rst_cur", 32'(bus4.cur_sel), 32'h1);

        // Mode change to direct on a terminal-count cycle: no tick.
        step(3);
        mode = 1'b0; sel = 3'd4; step(1);
        chk("mchg_tick", 32'(bus4.tick), 32'h0);
        chk("mchg_y_n", 32'(bus4.y_n), 32'h0000_00EF);
        step(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N decoder with active-low one-hot outputs and 74LS138-style three-input enable gating.
- Adds an auto-scan mode: an internal prescaler and index counter step the active output through channels 0..SCAN_LAST.
- Drives multiplexed 7-segment anodes (Basys3 digital clock) directly from the system clock; direct mode replaces the combinational decoder where a registered output is needed.

Parameters:
- SEL_W, 3, select width; output count NUM_OUT = 2^SEL_W.
- SCAN_LAST, 3, last channel index visited in scan mode; legal range 0..NUM_OUT-1.
- PRESCALE, 100000, clock cycles per scan step; must be >= 1. Counter width is derived as clog2(PRESCALE), minimum 1 bit.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset.
- e1, input, 1, enable, active high.
- e2_n, input, 1, enable, active low.
- e3_n, input, 1, enable, active low.
- mode, input, 1, 0 = direct decode of sel; 1 = auto scan.
- sel, input, SEL_W, channel select; used only when mode=0.
- y_n, output, NUM_OUT, registered active-low one-hot outputs.
- cur_sel, output, SEL_W, registered index of the currently decoded channel.
- tick, output, 1, one-cycle pulse on the cycle the scan index advances.

Behaviour:
- Reset (rst=1 at clock edge, overrides everything): y_n = all ones, cur_sel = 0, prescaler = 0, tick = 0.
- Enable term: en = e1 & ~e2_n & ~e3_n, sampled each cycle.
- y_n is always the registered image of the next cur_sel:
  - en=1: y_n[k] = 0 only for k == next cur_sel.
  - en=0: y_n = all ones.
- Direct mode (mode=0, en=1):
  - cur_sel <= sel every cycle, so y_n follows sel with 1-cycle latency.
  - prescaler <= 0; tick = 0.
- Scan mode (mode=1, en=1):
  - prescaler increments each cycle.
  - When prescaler == PRESCALE-1: prescaler <= 0, tick <= 1 for one cycle, and cur_sel advances.
  - Advance rule: if cur_sel >= SCAN_LAST then 0, else cur_sel+1. An out-of-range index (for example, left over from direct mode) returns to 0 at the first step.
  - PRESCALE=1: tick every cycle, index steps every cycle.
- Disabled (en=0, either mode):
  - cur_sel and prescaler hold; tick = 0; y_n = all ones.
  - On re-enable, operation resumes from the held index and count, with no lost or extra step.
- Mode change 0->1: scan starts from the current cur_sel with prescaler = 0. The first step comes PRESCALE cycles after the switch.
- Mode change 1->0: cur_sel <= sel on the next edge; the prescaler clears.
- Simultaneous events:
  - rst beats en and mode.
  - A mode change on the same cycle as a terminal count: the new mode wins and no tick is issued.
  - sel changes in scan mode are ignored.
- No combinational path from any input to any output.

Test Plan (SEL_W=3, SCAN_LAST=3, PRESCALE=4 unless stated):
- Reset/direct: hold rst=1 for 3 cycles -> y_n=8'hFF, cur_sel=0, tick=0. Release with en=1, mode=0, sel=5 -> one cycle later y_n=8'hDF, cur_sel=5.
- Direct sweep and enables: sel=0..7 with en=1 -> y_n = FE, FD, FB, F7, EF, DF, BF, 7F, each delayed one cycle. Then e1=0, or e2_n=1, or e3_n=1 -> y_n=8'hFF on the next cycle, cur_sel held.
- Scan run: en=1, mode=1 from cur_sel=0 for 20 cycles -> tick high every 4th cycle; y_n sequence FE, FD, FB, F7, FE. Channels 4..7 never go low. With PRESCALE=1 the index steps every cycle.
- Freeze/resume: in scan mode, drop e1 for 5 cycles when prescaler=2 and cur_sel=2 -> y_n=8'hFF, no tick. Restore e1 -> cur_sel=2 and y_n=FB; the next tick comes 2 cycles later, then cur_sel=3.
- Out-of-range entry: mode=0, sel=6, then mode=1 -> y_n=BF for 4 cycles; then tick and cur_sel=0 (y_n=FE).
- Reset mid-scan: assert rst at cur_sel=2, prescaler=3 -> next edge y_n=FF, no tick. After release, the first tick comes 4 cycles after scan restarts from 0.
